// File: rtl/ahb_apb_bridge_param.sv
// ---------------------------------------------------------------------------
// ahb_apb_bridge_param
//   AHB-Lite slave to APB4 master bridge. A slot field of HADDR selects one
//   PSEL line; PSTRB and PPROT are derived from the AHB control signals.
//   Unmapped slots, HSIZE > word and PSLVERR all return the two-cycle AHB
//   ERROR response (HREADYOUT low then high, HRESP high in both cycles).
//
//   Optional feature: define AHBAPB_TIMEOUT_EN to compile in an ACCESS-phase
//   timeout of TIMEOUT_CYCLES cycles. Without it, ACCESS waits for PREADY.
//
// Ports
//   HCLK, HRESET           clock, synchronous active-high reset
//   HSEL..HREADYIN         AHB-Lite slave inputs (address/control/data)
//   HREADYOUT, HRDATA,
//   HRESP                  AHB-Lite slave response
//   PSEL[NUM_SLOTS-1:0],
//   PADDR, PWRITE, PENABLE,
//   PWDATA, PSTRB, PPROT   APB4 master request
//   PRDATA, PREADY,
//   PSLVERR                APB4 completer response
// ---------------------------------------------------------------------------
module ahb_apb_bridge_param #(
   parameter int NUM_SLOTS      = 16,
   parameter int SLOT_LSB       = 24,
   parameter int SLOT_BITS      = 4,
   parameter int APB_AW         = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                 HCLK,
   input  logic                 HRESET,
   input  logic                 HSEL,
   input  logic [31:0]          HADDR,
   input  logic                 HWRITE,
   input  logic [1:0]           HTRANS,
   input  logic [2:0]           HSIZE,
   input  logic [3:0]           HPROT,
   input  logic [31:0]          HWDATA,
   input  logic                 HREADYIN,
   output logic                 HREADYOUT,
   output logic [31:0]          HRDATA,
   output logic                 HRESP,
   output logic [NUM_SLOTS-1:0] PSEL,
   output logic [APB_AW-1:0]    PADDR,
   output logic                 PWRITE,
   output logic                 PENABLE,
   output logic [31:0]          PWDATA,
   output logic [3:0]           PSTRB,
   output logic [2:0]           PPROT,
   input  logic [31:0]          PRDATA,
   input  logic                 PREADY,
   input  logic                 PSLVERR
);

   typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_ERR1, ST_ERR2} state_t;

   localparam int SLOT_W1 = SLOT_BITS + 1;

   state_t                 state_q, state_d;
   logic [APB_AW-1:0]      paddr_q, paddr_d;
   logic [SLOT_BITS-1:0]   slot_q, slot_d;
   logic                   pwrite_q, pwrite_d;
   logic [3:0]             pstrb_q, pstrb_d;
   logic [2:0]             pprot_q, pprot_d;
   logic [31:0]            pwdata_q, pwdata_d;

   logic                   start;
   logic                   take;
   logic [SLOT_BITS-1:0]   req_slot;
   logic                   req_bad;

   // HPROT[3:2], HTRANS[0] and HADDR bits above the APB window carry no meaning here.
   logic unused_bits;
   assign unused_bits = ^{HPROT[3:2], HTRANS[0], HADDR};

   // Byte lanes for a write; reads never strobe.
   function automatic logic [3:0] strb_for(input logic wr, input logic [2:0] size,
                                           input logic [1:0] a);
      logic [3:0] s;
      s = 4'b0000;
      if (wr) begin
         case (size)
            3'd0:    s = 4'b0001 << a;
            3'd1:    s = a[1] ? 4'b1100 : 4'b0011;
            3'd2:    s = 4'b1111;
            default: s = 4'b0000;
         endcase
      end
      return s;
   endfunction

   assign start    = HSEL & HREADYIN & HTRANS[1];
   assign req_slot = HADDR[SLOT_LSB +: SLOT_BITS];
   assign req_bad  = ({1'b0, req_slot} >= SLOT_W1'(NUM_SLOTS)) || (HSIZE > 3'd2);

`ifdef AHBAPB_TIMEOUT_EN
   localparam int CNT_W = 16;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout;

   // The stalled cycle that would bring the count to TIMEOUT_CYCLES is the
   // last ACCESS cycle; the bridge leaves for ERR1 on that edge.
   assign timeout = (state_q == ST_ACCESS) && !PREADY &&
                    (cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (state_q != ST_ACCESS)
         cnt_d = '0;
      else if (!PREADY)
         cnt_d = cnt_q + 1'b1;
   end
`else
   localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

   // Next-state and request capture
   always_comb begin
      state_d  = state_q;
      paddr_d  = paddr_q;
      slot_d   = slot_q;
      pwrite_d = pwrite_q;
      pstrb_d  = pstrb_q;
      pprot_d  = pprot_q;
      pwdata_d = pwdata_q;
      take     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) take = 1'b1;
         end
         ST_SETUP: begin
            state_d  = ST_ACCESS;
            pwdata_d = HWDATA;
         end
         ST_ACCESS: begin
            if (PREADY) begin
               if (PSLVERR)    state_d = ST_ERR1;
               else if (start) take    = 1'b1;
               else            state_d = ST_IDLE;
            end
`ifdef AHBAPB_TIMEOUT_EN
            else if (timeout) begin
               state_d = ST_ERR1;
            end
`endif
         end
         ST_ERR1: begin
            state_d = ST_ERR2;
         end
         ST_ERR2: begin
            if (start) take    = 1'b1;
            else       state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (take) begin
         paddr_d  = HADDR[APB_AW-1:0];
         slot_d   = req_slot;
         pwrite_d = HWRITE;
         pstrb_d  = strb_for(HWRITE, HSIZE, HADDR[1:0]);
         pprot_d  = {~HPROT[0], 1'b0, HPROT[1]};
         state_d  = req_bad ? ST_ERR1 : ST_SETUP;
      end
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q  <= ST_IDLE;
         paddr_q  <= '0;
         slot_q   <= '0;
         pwrite_q <= 1'b0;
         pstrb_q  <= 4'b0000;
         pprot_q  <= 3'b000;
         pwdata_q <= '0;
      end else begin
         state_q  <= state_d;
         paddr_q  <= paddr_d;
         slot_q   <= slot_d;
         pwrite_q <= pwrite_d;
         pstrb_q  <= pstrb_d;
         pprot_q  <= pprot_d;
         pwdata_q <= pwdata_d;
      end
   end

`ifdef AHBAPB_TIMEOUT_EN
   always_ff @(posedge HCLK) begin
      if (HRESET) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
`endif

   // Bus outputs decoded from state
   always_comb begin
      PSEL      = '0;
      PENABLE   = (state_q == ST_ACCESS);
      HRESP     = (state_q == ST_ERR1) || (state_q == ST_ERR2);
      HREADYOUT = 1'b1;
      // In SETUP the data phase is live on HWDATA, so it passes straight through.
      PWDATA    = (state_q == ST_SETUP) ? HWDATA : pwdata_q;

      case (state_q)
         ST_SETUP:  HREADYOUT = 1'b0;
         ST_ACCESS: HREADYOUT = PREADY & ~PSLVERR;
         ST_ERR1:   HREADYOUT = 1'b0;
         default:   HREADYOUT = 1'b1;
      endcase

      for (int i = 0; i < NUM_SLOTS; i++)
         PSEL[i] = ((state_q == ST_SETUP) || (state_q == ST_ACCESS)) &&
                   (slot_q == SLOT_BITS'(i));
   end

   assign PADDR  = paddr_q;
   assign PWRITE = pwrite_q;
   assign PSTRB  = pstrb_q;
   assign PPROT  = pprot_q;
   assign HRDATA = PRDATA;

endmodule

// File: tb/tb_ahb_apb_bridge_param.sv
// ---------------------------------------------------------------------------
// tb_ahb_apb_bridge_param
//   Bench for ahb_apb_bridge_param with NUM_SLOTS=8, TIMEOUT_CYCLES=4.
//   Inputs change 1 ns after the rising edge, outputs are sampled 4 ns after.
//   Expected APB requests are queued when the AHB address phase is driven and
//   popped when the matching ACCESS cycle is observed.
// ---------------------------------------------------------------------------
module tb_ahb_apb_bridge_param;

   logic        HCLK = 1'b0;
   logic        HRESET, HSEL, HWRITE, HREADYIN;
   logic [31:0] HADDR, HWDATA;
   logic [1:0]  HTRANS;
   logic [2:0]  HSIZE;
   logic [3:0]  HPROT;
   logic        HREADYOUT, HRESP;
   logic [31:0] HRDATA;
   logic [7:0]  PSEL;
   logic [31:0] PADDR, PWDATA, PRDATA;
   logic        PWRITE, PENABLE, PREADY, PSLVERR;
   logic [3:0]  PSTRB;
   logic [2:0]  PPROT;

   typedef struct {
      logic [7:0]  psel;
      logic [31:0] paddr;
      logic        pwrite;
      logic [3:0]  pstrb;
      logic [2:0]  pprot;
   } apb_exp_t;

   apb_exp_t sb[$];
   apb_exp_t e;
   int n_tests = 0;
   int n_fail  = 0;

   ahb_apb_bridge_param #(.NUM_SLOTS(8), .SLOT_LSB(24), .SLOT_BITS(4), .APB_AW(32),
                          .TIMEOUT_CYCLES(4)) dut (
      .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
      .HTRANS(HTRANS), .HSIZE(HSIZE), .HPROT(HPROT), .HWDATA(HWDATA),
      .HREADYIN(HREADYIN), .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HRESP(HRESP),
      .PSEL(PSEL), .PADDR(PADDR), .PWRITE(PWRITE), .PENABLE(PENABLE),
      .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT), .PRDATA(PRDATA),
      .PREADY(PREADY), .PSLVERR(PSLVERR)
   );

   always #5 HCLK = ~HCLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
      $fatal(1, "watchdog");
   end

   task automatic cyc;
      @(posedge HCLK);
      #1;
   endtask

   task automatic bus_idle;
      HSEL = 1'b0; HTRANS = 2'b00; HADDR = 32'h0; HWRITE = 1'b0; HSIZE = 3'd0; HPROT = 4'h0;
   endtask

   task automatic addr_phase(input logic [31:0] a, input logic w, input logic [2:0] sz,
                             input logic [3:0] prot);
      HSEL = 1'b1; HTRANS = 2'b10; HADDR = a; HWRITE = w; HSIZE = sz; HPROT = prot;
   endtask

   task automatic test_reset;
      HRESET = 1'b1; bus_idle(); HWDATA = 32'h0; HREADYIN = 1'b1;
      PREADY = 1'b1; PSLVERR = 1'b0; PRDATA = 32'h0;
      repeat (2) cyc();
      #3;
      n_tests++;
      if ({PSEL, PENABLE, PWRITE} !== 10'h0) begin
         n_fail++; $display("FAIL reset_ctl: psel=%h penable=%b pwrite=%b, want 0", PSEL, PENABLE, PWRITE);
      end
      n_tests++;
      if ({PADDR, PWDATA} !== 64'h0) begin
         n_fail++; $display("FAIL reset_data: paddr=%h pwdata=%h, want 0", PADDR, PWDATA);
      end
      n_tests++;
      if ({PSTRB, PPROT} !== 7'h0) begin
         n_fail++; $display("FAIL reset_strb_prot: pstrb=%b pprot=%b, want 0", PSTRB, PPROT);
      end
      n_tests++;
      if ({HREADYOUT, HRESP} !== 2'b10) begin
         n_fail++; $display("FAIL reset_resp: hreadyout=%b hresp=%b, want 1/0", HREADYOUT, HRESP);
      end
      cyc(); HRESET = 1'b0;
   endtask

   task automatic test_write_zero_wait;
      int low_cnt;
      low_cnt = 0;
      cyc(); addr_phase(32'h0300_0004, 1'b1, 3'd2, 4'b0011); PREADY = 1'b1;
      sb.push_back('{8'h08, 32'h0300_0004, 1'b1, 4'hF, 3'b001});
      #3; if (!HREADYOUT) low_cnt++;
      cyc(); bus_idle(); HWDATA = 32'hA5A5_1234;
      #3; if (!HREADYOUT) low_cnt++;
      n_tests++;
      if ({PSEL, PENABLE, PWDATA} !== {8'h08, 1'b0, 32'hA5A5_1234}) begin
         n_fail++; $display("FAIL wr_setup: psel=%h penable=%b pwdata=%h, want 08/0/a5a51234", PSEL, PENABLE, PWDATA);
      end
      cyc(); HWDATA = 32'h0;
      #3; if (!HREADYOUT) low_cnt++;
      n_tests++;
      if ({PENABLE, PWDATA, HREADYOUT, HRESP} !== {1'b1, 32'hA5A5_1234, 1'b1, 1'b0}) begin
         n_fail++; $display("FAIL wr_access: penable=%b pwdata=%h hready=%b hresp=%b, want 1/a5a51234/1/0", PENABLE, PWDATA, HREADYOUT, HRESP);
      end
      n_tests++;
      if (sb.size() == 0) begin n_fail++; $display("FAIL wr_sb: no expected entry"); end
      else begin
         e = sb.pop_front();
         if ({PSEL, PADDR, PWRITE, PSTRB, PPROT} !== {e.psel, e.paddr, e.pwrite, e.pstrb, e.pprot}) begin
            n_fail++; $display("FAIL wr_apb: got %h %h %b %b %b, want %h %h %b %b %b", PSEL, PADDR, PWRITE, PSTRB, PPROT, e.psel, e.paddr, e.pwrite, e.pstrb, e.pprot);
         end
      end
      cyc();
      #3; if (!HREADYOUT) low_cnt++;
      n_tests++;
      if ({PSEL, PENABLE} !== 9'h0) begin
         n_fail++; $display("FAIL wr_idle: psel=%h penable=%b, want 0", PSEL, PENABLE);
      end
      n_tests++;
      if (low_cnt !== 1) begin
         n_fail++; $display("FAIL wr_hready_low: %0d cycles low, want 1", low_cnt);
      end
   endtask

   task automatic test_read_wait;
      int acc;
      acc = 0;
      cyc(); addr_phase(32'h0500_0010, 1'b0, 3'd2, 4'b0000); PREADY = 1'b0;
      sb.push_back('{8'h20, 32'h0500_0010, 1'b0, 4'h0, 3'b100});
      cyc(); bus_idle();
      #3;
      n_tests++;
      if ({PSEL, PENABLE, HREADYOUT} !== {8'h20, 1'b0, 1'b0}) begin
         n_fail++; $display("FAIL rd_setup: psel=%h penable=%b hready=%b, want 20/0/0", PSEL, PENABLE, HREADYOUT);
      end
      for (int i = 0; i < 4; i++) begin
         cyc(); PREADY = (i == 3); PRDATA = (i == 3) ? 32'hDEAD_BEEF : 32'h0;
         #3; if (PENABLE) acc++;
         n_tests++;
         if (i < 3) begin
            if (HREADYOUT !== 1'b0) begin
               n_fail++; $display("FAIL rd_wait%0d: hready=%b, want 0", i, HREADYOUT);
            end
         end else begin
            if ({HREADYOUT, HRDATA} !== {1'b1, 32'hDEAD_BEEF}) begin
               n_fail++; $display("FAIL rd_data: hready=%b hrdata=%h, want 1/deadbeef", HREADYOUT, HRDATA);
            end
            n_tests++;
            if (sb.size() == 0) begin n_fail++; $display("FAIL rd_sb: no expected entry"); end
            else begin
               e = sb.pop_front();
               if ({PSEL, PADDR, PWRITE, PSTRB, PPROT} !== {e.psel, e.paddr, e.pwrite, e.pstrb, e.pprot}) begin
                  n_fail++; $display("FAIL rd_apb: got %h %h %b %b %b, want %h %h %b %b %b", PSEL, PADDR, PWRITE, PSTRB, PPROT, e.psel, e.paddr, e.pwrite, e.pstrb, e.pprot);
               end
            end
         end
      end
      cyc(); PREADY = 1'b1; PRDATA = 32'h0;
      #3;
      n_tests++;
      if (acc !== 4 || PENABLE !== 1'b0) begin
         n_fail++; $display("FAIL rd_access_len: %0d access cycles penable=%b, want 4/0", acc, PENABLE);
      end
   endtask

   task automatic test_back_to_back;
      cyc(); addr_phase(32'h0100_0002, 1'b1, 3'd0, 4'h0); PREADY = 1'b1;
      sb.push_back('{8'h02, 32'h0100_0002, 1'b1, 4'b0100, 3'b100});
      cyc(); addr_phase(32'h0100_0002, 1'b1, 3'd1, 4'h0); HWDATA = 32'h0000_0011;
      sb.push_back('{8'h02, 32'h0100_0002, 1'b1, 4'b1100, 3'b100});
      #3;
      n_tests++;
      if ({PSEL, PENABLE, PSTRB} !== {8'h02, 1'b0, 4'b0100}) begin
         n_fail++; $display("FAIL b2b_setup_a: psel=%h penable=%b pstrb=%b, want 02/0/0100", PSEL, PENABLE, PSTRB);
      end
      for (int k = 0; k < 2; k++) begin
         cyc();
         if (k == 1) begin bus_idle(); HWDATA = 32'h0000_2200; end
         #3;
         if (k == 1) begin
            n_tests++;
            if ({PSEL, PENABLE, PSTRB, PWDATA} !== {8'h02, 1'b0, 4'b1100, 32'h0000_2200}) begin
               n_fail++; $display("FAIL b2b_setup_b: psel=%h penable=%b pstrb=%b pwdata=%h, want 02/0/1100/00002200", PSEL, PENABLE, PSTRB, PWDATA);
            end
            cyc(); #3;
         end
         n_tests++;
         if ({PENABLE, HREADYOUT} !== 2'b11) begin
            n_fail++; $display("FAIL b2b_access%0d: penable=%b hready=%b, want 1/1", k, PENABLE, HREADYOUT);
         end
         n_tests++;
         if (sb.size() == 0) begin n_fail++; $display("FAIL b2b_sb%0d: no expected entry", k); end
         else begin
            e = sb.pop_front();
            if ({PSEL, PADDR, PWRITE, PSTRB, PPROT} !== {e.psel, e.paddr, e.pwrite, e.pstrb, e.pprot}) begin
               n_fail++; $display("FAIL b2b_apb%0d: got %h %h %b %b %b, want %h %h %b %b %b", k, PSEL, PADDR, PWRITE, PSTRB, PPROT, e.psel, e.paddr, e.pwrite, e.pstrb, e.pprot);
            end
         end
      end
      cyc(); #3;
   endtask

   task automatic test_slverr;
      cyc(); addr_phase(32'h0200_0000, 1'b1, 3'd2, 4'b0001); PREADY = 1'b1;
      sb.push_back('{8'h04, 32'h0200_0000, 1'b1, 4'hF, 3'b000});
      cyc(); bus_idle(); HWDATA = 32'h5555_AAAA; PSLVERR = 1'b1;
      cyc(); #3;
      n_tests++;
      if ({PENABLE, HREADYOUT, HRESP} !== 3'b100) begin
         n_fail++; $display("FAIL slverr_access: penable=%b hready=%b hresp=%b, want 1/0/0", PENABLE, HREADYOUT, HRESP);
      end
      n_tests++;
      if (sb.size() == 0) begin n_fail++; $display("FAIL slverr_sb: no expected entry"); end
      else begin
         e = sb.pop_front();
         if ({PSEL, PADDR, PWRITE, PSTRB, PPROT} !== {e.psel, e.paddr, e.pwrite, e.pstrb, e.pprot}) begin
            n_fail++; $display("FAIL slverr_apb: got %h %h %b %b %b, want %h %h %b %b %b", PSEL, PADDR, PWRITE, PSTRB, PPROT, e.psel, e.paddr, e.pwrite, e.pstrb, e.pprot);
         end
      end
      cyc(); PSLVERR = 1'b0; #3;
      n_tests++;
      if ({PSEL, PENABLE, HREADYOUT, HRESP} !== {8'h00, 1'b0, 1'b0, 1'b1}) begin
         n_fail++; $display("FAIL slverr_err1: psel=%h penable=%b hready=%b hresp=%b, want 00/0/0/1", PSEL, PENABLE, HREADYOUT, HRESP);
      end
      cyc(); #3;
      n_tests++;
      if ({HREADYOUT, HRESP} !== 2'b11) begin
         n_fail++; $display("FAIL slverr_err2: hready=%b hresp=%b, want 1/1", HREADYOUT, HRESP);
      end
      cyc(); #3;
      n_tests++;
      if ({HREADYOUT, HRESP} !== 2'b10) begin
         n_fail++; $display("FAIL slverr_done: hready=%b hresp=%b, want 1/0", HREADYOUT, HRESP);
      end
   endtask

   task automatic test_decode_err;
      logic [31:0] a;
      logic [2:0]  sz;
      logic [7:0]  sel_seen;
      for (int c = 0; c < 2; c++) begin
         a  = (c == 0) ? 32'h0F00_0000 : 32'h0100_0000;
         sz = (c == 0) ? 3'd2 : 3'd3;
         cyc(); addr_phase(a, 1'b1, sz, 4'h0);
         cyc(); bus_idle(); #3;
         sel_seen = PSEL;
         n_tests++;
         if ({HREADYOUT, HRESP} !== 2'b01) begin
            n_fail++; $display("FAIL dec%0d_err1: hready=%b hresp=%b, want 0/1", c, HREADYOUT, HRESP);
         end
         cyc(); #3;
         sel_seen = sel_seen | PSEL;
         n_tests++;
         if ({HREADYOUT, HRESP} !== 2'b11) begin
            n_fail++; $display("FAIL dec%0d_err2: hready=%b hresp=%b, want 1/1", c, HREADYOUT, HRESP);
         end
         n_tests++;
         if (sel_seen !== 8'h00) begin
            n_fail++; $display("FAIL dec%0d_no_psel: psel seen=%h, want 00", c, sel_seen);
         end
         cyc(); #3;
         n_tests++;
         if ({HREADYOUT, HRESP, PSEL} !== {2'b10, 8'h00}) begin
            n_fail++; $display("FAIL dec%0d_done: hready=%b hresp=%b psel=%h, want 1/0/00", c, HREADYOUT, HRESP, PSEL);
         end
      end
   endtask

   task automatic test_reset_mid;
      cyc(); addr_phase(32'h0300_0000, 1'b1, 3'd2, 4'h0); PREADY = 1'b0;
      sb.push_back('{8'h08, 32'h0300_0000, 1'b1, 4'hF, 3'b100});
      cyc(); bus_idle(); HWDATA = 32'h0000_0001;
      cyc(); #3;
      n_tests++;
      if ({PENABLE, HREADYOUT} !== 2'b10) begin
         n_fail++; $display("FAIL rstmid_access: penable=%b hready=%b, want 1/0", PENABLE, HREADYOUT);
      end
      n_tests++;
      if (sb.size() == 0) begin n_fail++; $display("FAIL rstmid_sb: no expected entry"); end
      else begin
         e = sb.pop_front();
         if ({PSEL, PADDR, PWRITE, PSTRB, PPROT} !== {e.psel, e.paddr, e.pwrite, e.pstrb, e.pprot}) begin
            n_fail++; $display("FAIL rstmid_apb: got %h %h %b %b %b, want %h %h %b %b %b", PSEL, PADDR, PWRITE, PSTRB, PPROT, e.psel, e.paddr, e.pwrite, e.pstrb, e.pprot);
         end
      end
      HRESET = 1'b1;
      cyc(); HRESET = 1'b0; #3;
      n_tests++;
      if ({PSEL, PENABLE, HREADYOUT, HRESP} !== {8'h00, 1'b0, 1'b1, 1'b0}) begin
         n_fail++; $display("FAIL rstmid_drop: psel=%h penable=%b hready=%b hresp=%b, want 00/0/1/0", PSEL, PENABLE, HREADYOUT, HRESP);
      end
      PREADY = 1'b1;
      cyc(); addr_phase(32'h0400_0008, 1'b1, 3'd2, 4'h0);
      sb.push_back('{8'h10, 32'h0400_0008, 1'b1, 4'hF, 3'b100});
      cyc(); bus_idle(); HWDATA = 32'hCAFE_F00D; #3;
      n_tests++;
      if ({PSEL, PENABLE, PWDATA} !== {8'h10, 1'b0, 32'hCAFE_F00D}) begin
         n_fail++; $display("FAIL rstmid_next_setup: psel=%h penable=%b pwdata=%h, want 10/0/cafef00d", PSEL, PENABLE, PWDATA);
      end
      cyc(); #3;
      n_tests++;
      if (sb.size() == 0) begin n_fail++; $display("FAIL rstmid_next_sb: no expected entry"); end
      else begin
         e = sb.pop_front();
         if ({PSEL, PADDR, PWRITE, PSTRB, PPROT, PENABLE, HREADYOUT} !== {e.psel, e.paddr, e.pwrite, e.pstrb, e.pprot, 2'b11}) begin
            n_fail++; $display("FAIL rstmid_next_apb: got %h %h %b %b %b en=%b rdy=%b, want %h %h %b %b %b en=1 rdy=1", PSEL, PADDR, PWRITE, PSTRB, PPROT, PENABLE, HREADYOUT, e.psel, e.paddr, e.pwrite, e.pstrb, e.pprot);
         end
      end
      cyc(); #3;
   endtask

   task automatic test_timeout;
      int acc;
      int bad;
      bit done;
      acc = 0; bad = 0; done = 1'b0;
      cyc(); addr_phase(32'h0600_0000, 1'b0, 3'd2, 4'h0); PREADY = 1'b0;
      sb.push_back('{8'h40, 32'h0600_0000, 1'b0, 4'h0, 3'b100});
      cyc(); bus_idle();
      cyc(); #3;
      if (PENABLE) acc++;
      n_tests++;
      if (sb.size() == 0) begin n_fail++; $display("FAIL to_sb: no expected entry"); end
      else begin
         e = sb.pop_front();
         if ({PSEL, PADDR, PWRITE, PSTRB, PPROT} !== {e.psel, e.paddr, e.pwrite, e.pstrb, e.pprot}) begin
            n_fail++; $display("FAIL to_apb: got %h %h %b %b %b, want %h %h %b %b %b", PSEL, PADDR, PWRITE, PSTRB, PPROT, e.psel, e.paddr, e.pwrite, e.pstrb, e.pprot);
         end
      end
`ifdef AHBAPB_TIMEOUT_EN
      for (int i = 0; i < 20 && !done; i++) begin
         cyc(); #3;
         if (PENABLE) acc++;
         else done = 1'b1;
      end
      n_tests++;
      if (!done || acc !== 4 || {PSEL, HREADYOUT, HRESP} !== {8'h00, 2'b01}) begin
         n_fail++; $display("FAIL to_err1: ended=%b access=%0d psel=%h hready=%b hresp=%b, want 1/4/00/0/1", done, acc, PSEL, HREADYOUT, HRESP);
      end
      cyc(); #3;
      n_tests++;
      if ({HREADYOUT, HRESP} !== 2'b11) begin
         n_fail++; $display("FAIL to_err2: hready=%b hresp=%b, want 1/1", HREADYOUT, HRESP);
      end
      PREADY = 1'b1;
      cyc(); #3;
`else
      for (int i = 0; i < 1000; i++) begin
         cyc(); #3;
         if (HREADYOUT !== 1'b0 || PENABLE !== 1'b1 || HRESP !== 1'b0) bad++;
      end
      n_tests++;
      if (bad !== 0 || done) begin
         n_fail++; $display("FAIL to_stuck: %0d of 1000 cycles left the wait state, want 0", bad);
      end
      cyc(); PREADY = 1'b1; PRDATA = 32'h1234_5678; #3;
      n_tests++;
      if ({HREADYOUT, HRESP, HRDATA} !== {2'b10, 32'h1234_5678}) begin
         n_fail++; $display("FAIL to_release: hready=%b hresp=%b hrdata=%h, want 1/0/12345678", HREADYOUT, HRESP, HRDATA);
      end
      cyc(); PRDATA = 32'h0; #3;
`endif
   endtask

   initial begin
      test_reset();
      test_write_zero_wait();
      test_read_wait();
      test_back_to_back();
      test_slverr();
      test_decode_err();
      test_reset_mid();
      test_timeout();
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++; $display("FAIL sb_leftover: %0d expected transfers never seen", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ahb_apb_bridge_param.md
Name: ahb_apb_bridge_param

Overview:
Parametrised AHB-Lite slave to APB4 master bridge and next-generation BFM bridge for the AMBA test benches. It decodes a configurable slot field into one PSEL per APB slave and generates PSTRB/PPROT from the AHB control signals. It returns a proper two-cycle AHB ERROR response on PSLVERR, on an unmapped slot, or on an unsupported HSIZE. An optional APB timeout can be compiled in.

Parameters:
NUM_SLOTS, 16, number of PSEL outputs (1..16)
SLOT_LSB, 24, LSB of the slot index field in HADDR
SLOT_BITS, 4, width of the slot index field; requires 2**SLOT_BITS >= NUM_SLOTS
APB_AW, 32, PADDR width (PADDR = HADDR[APB_AW-1:0])
TIMEOUT_CYCLES, 255, maximum number of ACCESS cycles (used only with AHBAPB_TIMEOUT_EN)

Ports:
HCLK  in  1  clock; all logic on rising edge
HRESET  in  1  synchronous reset, active-high
HSEL  in  1  bridge select
HADDR  in  32  AHB address
HWRITE  in  1  1 = write
HTRANS  in  2  AHB transfer type; only NONSEQ/SEQ (HTRANS[1]=1) start a transfer
HSIZE  in  3  transfer size
HPROT  in  4  protection
HWDATA  in  32  write data (data phase)
HREADYIN  in  1  AHB bus ready
HREADYOUT  out  1  slave ready
HRDATA  out  32  read data
HRESP  out  1  1 = ERROR
PSEL  out  NUM_SLOTS  one-hot APB select
PADDR  out  APB_AW  APB address
PWRITE  out  1  APB direction
PENABLE  out  1  APB enable
PWDATA  out  32  APB write data
PSTRB  out  4  APB4 byte strobes
PPROT  out  3  APB4 protection
PRDATA  in  32  APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB slave error

Behaviour:
- States: IDLE, SETUP, ACCESS, ERR1, ERR2.
- Reset: state=IDLE; PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, PSTRB=0, PPROT=0, HRESP=0, HREADYOUT=1. A reset asserted mid-transfer drops PSEL/PENABLE at the next edge regardless of PREADY.
- Start condition: HSEL & HREADYIN & HTRANS[1]. Sampled in IDLE, in ERR2, and in ACCESS on the completing cycle.
  - On start, capture HADDR, HWRITE, HSIZE, HPROT.
  - Unmapped slot (HADDR slot field >= NUM_SLOTS) or HSIZE > 2 -> go to ERR1 with no APB cycle.
  - Otherwise -> go to SETUP.
- SETUP (1 cycle): PSEL[slot]=1, PENABLE=0, HREADYOUT=0, PWDATA driven combinationally from HWDATA and registered at the edge. Next state: ACCESS.
- ACCESS: PENABLE=1, PWDATA holds the registered value, HREADYOUT = PREADY & ~PSLVERR.
  - PREADY & ~PSLVERR: transfer completes. Go to SETUP if a new start is present, else IDLE.
  - PREADY & PSLVERR: go to ERR1.
  - ~PREADY: stay in ACCESS (wait state).
- ERR1: PSEL=0, PENABLE=0, HREADYOUT=0, HRESP=1.
- ERR2: HREADYOUT=1, HRESP=1. Next state: IDLE, or SETUP/ERR1 if a new start is present.
- Latency: a zero-wait APB slave gives 2 AHB data-phase cycles (SETUP plus ACCESS). Back-to-back transfers leave no idle APB cycle.
- HRDATA = PRDATA (combinational); valid when HREADYOUT=1 in ACCESS.
- PSTRB applies to writes only; reads give PSTRB=0.
  - HSIZE=0 (byte): PSTRB = 1<<HADDR[1:0].
  - HSIZE=1 (halfword): 4'b0011 if HADDR[1]=0, else 4'b1100.
  - HSIZE=2 (word): 4'b1111.
- PPROT = {~HPROT[0], 1'b0, HPROT[1]}.
- IDLE/BUSY transfers (HTRANS[1]=0) get a zero-wait OKAY. With HSEL=0 the bridge drives HREADYOUT=1, HRESP=0.

Optional Feature:
AHBAPB_TIMEOUT_EN
- Defined: an 8..16-bit counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0. When it reaches TIMEOUT_CYCLES, the bridge deasserts PSEL/PENABLE at the next edge and goes to ERR1. If PREADY=1 on that same cycle, the transfer completes normally instead.
- Undefined: no counter; ACCESS waits indefinitely for PREADY.

Test Plan:
- Zero-wait write: HADDR=0x0300_0004, HSIZE=2, HWDATA=0xA5A5_1234, PREADY=1 -> PSEL=0x0008, PADDR=0x0300_0004, PSTRB=4'hF, PWDATA=0xA5A5_1234 stable through SETUP/ACCESS, HREADYOUT low for exactly 1 cycle, HRESP=0.
- Read with 3 wait states from slot 5, PRDATA=0xDEAD_BEEF -> ACCESS held 4 cycles, HREADYOUT=1 only on the last, HRDATA=0xDEAD_BEEF, PSTRB=0.
- Byte write to HADDR=0x0100_0002, then halfword write to 0x0100_0002 -> PSTRB=4'b0100, then 4'b1100; no IDLE cycle between the two APB transfers.
- PSLVERR=1 with PREADY=1; separately, HADDR slot 0xF with NUM_SLOTS=8 -> HRESP=1 for two cycles with HREADYOUT 0 then 1; slot 0xF case issues no PSEL.
- HRESET pulsed during ACCESS with PREADY=0 -> next edge PSEL=0, PENABLE=0, HREADYOUT=1, state IDLE; the following transfer runs normally.
- AHBAPB_TIMEOUT_EN, TIMEOUT_CYCLES=4, PREADY stuck 0 -> ERR1 entered after 4 ACCESS cycles, two-cycle ERROR response; without the macro, no response after 1000 cycles.
